// File: rtl/cond_check_stage.sv
`default_nettype none
// ============================================================================
// Module   : cond_check_stage
// Purpose  : NZCV status register plus condition-code evaluation, producing a
//            registered execute/squash decision over a valid/ready handshake.
//            Optional macro CC_PERF_CNT_EN adds saturating exec/skip counters.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check_stage #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    input  logic             flags_pend,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exec,
    output logic [TAG_W-1:0] out_tag,
`ifdef CC_PERF_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt,
`endif
    output logic [3:0]       nzcv_q
);

    localparam logic [3:0] C_COND_AL = 4'b1110;
    localparam logic [3:0] C_COND_NV = 4'b1111;

    logic [3:0] w_eff;
    logic       w_pass;
    logic       w_haz;
    logic       w_accept;
    logic       w_n, w_z, w_c, w_v;

    // Same-cycle flag update is forwarded into the evaluation.
    assign w_eff = flags_we ? flags_in : nzcv_q;
    assign {w_n, w_z, w_c, w_v} = w_eff;

    always_comb begin
        w_pass = 1'b0;
        case (in_cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = !w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = !w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = !w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = !w_v;
            4'b1000: w_pass = w_c & !w_z;
            4'b1001: w_pass = !w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = !w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    // AL and NV do not read the flags, so they never wait on a pending write.
    assign w_haz    = flags_pend & !flags_we & (in_cond != C_COND_AL) & (in_cond != C_COND_NV);
    assign in_ready = !w_haz & (!out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= 4'b0000;
        end else if (flags_we) begin
            nzcv_q <= flags_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_exec  <= 1'b0;
            out_tag   <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_exec  <= w_pass;
            out_tag   <= in_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (cnt_clr) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (w_accept) begin
            if (w_pass) begin
                if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
            end else begin
                if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
